key_device: RTL and testbench
=============================

KEY_DEVICE -- requirements
Module: key_device

Interface
REQ-001 SHALL have parameter DBITS, default 32, data bus width.
REQ-002 SHALL have parameter ADDRKDATA, default 32'hFFFF0100, KDATA register address.
REQ-003 SHALL have parameter ADDRKCTRL, default 32'hFFFF0104, KCTRL register address.
REQ-004 SHALL have parameter DEBCYCLES, default 10000, stable-sample count required before accepting a key change (minimum 2).
REQ-005 SHALL have port CLK, input, 1, single clock for all logic.
REQ-006 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-007 SHALL have port ADDRIN, input, DBITS, byte address from the processor memory stage.
REQ-008 SHALL have port DIN, input, DBITS, write data.
REQ-009 SHALL have port WE, input, 1, write strobe.
REQ-010 SHALL have port RE, input, 1, read strobe, asserted for exactly one cycle per load instruction.
REQ-011 SHALL have port DOUT, output, DBITS, read data.
REQ-012 SHALL have port SEL, output, 1, high when ADDRIN matches ADDRKDATA or ADDRKCTRL.
REQ-013 SHALL have port KEY, input, 4, raw asynchronous board keys, active-low.
REQ-014 SHALL have port INTR, output, 1, interrupt request.

Function
REQ-015 SHALL pass KEY through a 2-flop synchronizer before any other use.
REQ-016 SHALL hold a candidate value: when the synchronized value differs from the candidate, load the candidate and clear the counter; otherwise increment the counter, saturating at DEBCYCLES-1.
REQ-017 SHALL load the stable value from the candidate on the edge after the counter equals DEBCYCLES-1 and the candidate differs from the stable value.
REQ-018 SHALL update the stable value exactly DEBCYCLES+2 edges after the first edge that samples a steady KEY change, where the first sampling edge is edge 0.
REQ-019 SHALL ignore pulses on KEY shorter than DEBCYCLES cycles; stable is unchanged.
REQ-020 SHALL return KDATA = {DBITS-4 zeros, stable[3:0]}.
REQ-021 SHALL return KCTRL = bit0 Ready, bit2 Overrun, bit4 IE; all other bits SHALL read 0.
REQ-022 SHALL set Ready on the edge where stable changes.
REQ-023 SHALL also set Overrun on that edge if Ready is already 1.
REQ-024 SHALL clear Ready on the edge where RE is high and ADDRIN equals ADDRKDATA.
REQ-025 SHALL keep Ready at 1 with Overrun unchanged when a KDATA read and a stable change occur on the same edge.
REQ-026 SHALL treat a write to KCTRL as follows: DIN bit0=0 clears Ready and bit0=1 is ignored; DIN bit2=0 clears Overrun and bit2=1 is ignored; DIN bit4 loads IE.
REQ-027 SHALL let set win on the same edge when a stable change coincides with a KCTRL write that clears Ready.
REQ-028 SHALL ignore writes to KDATA.
REQ-029 SHALL drive DOUT and SEL combinationally from ADDRIN and the current registers.
REQ-030 SHALL drive DOUT to 0 when SEL is low.
REQ-031 SHALL drive INTR = Ready AND IE, combinationally from registers.

Reset
REQ-032 SHALL, on RESET, load synchronizer flops, candidate and stable with 4'hF, counter with 0, and Ready, Overrun and IE with 0.
REQ-033 SHALL, with RESET asserted, output INTR=0, SEL per ADDRIN, and DOUT showing reset values on the next cycle.
REQ-034 SHALL abort any debounce in progress when RESET is asserted mid-operation; a KEY still held after reset SHALL be re-debounced from a count of 0.

Structure
REQ-035 SHALL place the KDATA/KCTRL address constants and the KCTRL bit positions (READY=0, OVERRUN=2, IE=4) in the shared project package, also used by the top level and Dmem decode.
REQ-036 SHALL implement synchronizer, candidate, counter and stable as one sub-module, key_debounce, parameterized by DEBCYCLES; register and bus logic SHALL stay in key_device.

Verification (bench uses DEBCYCLES=4)
REQ-037 Reset then KEY=4'hF steady, read KDATA and KCTRL -> DOUT=32'h0000000F, then 32'h0, INTR=0.
REQ-038 KEY 4'hF->4'hE steady -> KDATA=32'h0000000E exactly 6 edges after first sampling edge, KCTRL=32'h1, then one KDATA read -> KCTRL=32'h0.
REQ-039 KEY glitch to 4'hE for 3 cycles then back to 4'hF -> KDATA stays 32'hF, KCTRL stays 32'h0.
REQ-040 Two debounced changes (4'hE then 4'hC) without a read -> KCTRL=32'h5; write KCTRL DIN=32'h0 -> KCTRL=32'h0.
REQ-041 Write KCTRL DIN=32'h10, then a debounced key change -> INTR rises on the same edge Ready sets; a KDATA read that coincides with a second change -> Ready stays 1, INTR stays 1.
REQ-042 RESET asserted mid-debounce with KEY held 4'h7 -> all registers return to reset values; KDATA=32'h7 exactly 6 edges after RESET deasserts.

Source files
------------

// File: rtl/key_device_pkg.sv
// Shared project constants for the key device: bus addresses and KCTRL bit layout.
// Also used by the data-memory decode to steer loads/stores to the device.
package key_device_pkg;

  localparam logic [31:0] ADDR_KDATA = 32'hFFFF0100;
  localparam logic [31:0] ADDR_KCTRL = 32'hFFFF0104;

  localparam int unsigned KCTRL_READY   = 0;
  localparam int unsigned KCTRL_OVERRUN = 2;
  localparam int unsigned KCTRL_IE      = 4;

  // Keys are active-low, so "nothing pressed" is all ones.
  localparam logic [3:0] KEY_IDLE = 4'hF;

  typedef struct packed {
    logic ready;
    logic overrun;
    logic ie;
  } kctrl_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes the raw keys and accepts a new value only after DEBCYCLES stable samples.
// 'load' is high in the cycle whose closing edge updates 'stable'.
module key_debounce
  import key_device_pkg::*;
#(
  parameter int unsigned DEBCYCLES = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key,
  output logic [3:0] stable,
  output logic       load
);

  localparam int unsigned CntW = $clog2(DEBCYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBCYCLES - 1);

  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      stable_q, stable_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign load     = (cnt_q == CntMax) && (cand_q != stable_q);
  assign stable_d = load ? cand_q : stable_q;
  assign stable   = stable_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= KEY_IDLE;
      sync2_q  <= KEY_IDLE;
      cand_q   <= KEY_IDLE;
      cnt_q    <= '0;
      stable_q <= KEY_IDLE;
    end else begin
      sync1_q  <= key;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/key_device.sv
// Memory-mapped key device: debounced KDATA plus KCTRL (Ready/Overrun/IE) and an interrupt.
// Bus read data and select are purely combinational from the address and current registers.
module key_device
  import key_device_pkg::*;
#(
  parameter int unsigned       DBITS     = 32,
  parameter logic [DBITS-1:0]  ADDRKDATA = DBITS'(ADDR_KDATA),
  parameter logic [DBITS-1:0]  ADDRKCTRL = DBITS'(ADDR_KCTRL),
  parameter int unsigned       DEBCYCLES = 10000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [DBITS-1:0] ADDRIN,
  input  logic [DBITS-1:0] DIN,
  input  logic             WE,
  input  logic             RE,
  output logic [DBITS-1:0] DOUT,
  output logic             SEL,
  input  logic [3:0]       KEY,
  output logic             INTR
);

  logic [3:0]       stable;
  logic             key_load;
  kctrl_t           ctrl_q, ctrl_d;
  logic             is_kdata, is_kctrl;
  logic             kdata_rd, kctrl_wr;
  logic [DBITS-1:0] kdata_word, kctrl_word;
  logic             unused_din;

  key_debounce #(
    .DEBCYCLES(DEBCYCLES)
  ) u_debounce (
    .clk   (CLK),
    .reset (RESET),
    .key   (KEY),
    .stable(stable),
    .load  (key_load)
  );

  assign is_kdata = (ADDRIN == ADDRKDATA);
  assign is_kctrl = (ADDRIN == ADDRKCTRL);
  assign kdata_rd = RE && is_kdata;
  assign kctrl_wr = WE && is_kctrl;

  // Only DIN bits 0, 2 and 4 carry meaning for a KCTRL write.
  assign unused_din = ^DIN;

  // Clears apply first so that a coincident key change (set) wins.
  always_comb begin
    ctrl_d = ctrl_q;
    if (kdata_rd) ctrl_d.ready = 1'b0;
    if (kctrl_wr) begin
      if (!DIN[KCTRL_READY])   ctrl_d.ready   = 1'b0;
      if (!DIN[KCTRL_OVERRUN]) ctrl_d.overrun = 1'b0;
      ctrl_d.ie = DIN[KCTRL_IE];
    end
    if (key_load) begin
      ctrl_d.ready = 1'b1;
      // A read consuming the old value in the same cycle means nothing was lost.
      if (ctrl_q.ready && !kdata_rd) ctrl_d.overrun = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  always_comb begin
    kdata_word       = '0;
    kdata_word[3:0]  = stable;
    kctrl_word                = '0;
    kctrl_word[KCTRL_READY]   = ctrl_q.ready;
    kctrl_word[KCTRL_OVERRUN] = ctrl_q.overrun;
    kctrl_word[KCTRL_IE]      = ctrl_q.ie;
  end

  always_comb begin
    DOUT = '0;
    if (is_kdata) begin
      DOUT = kdata_word;
    end else if (is_kctrl) begin
      DOUT = kctrl_word;
    end
  end

  assign SEL  = is_kdata || is_kctrl;
  assign INTR = ctrl_q.ready && ctrl_q.ie;

endmodule

// File: tb/tb_key_device.sv
// Directed bench for key_device with DEBCYCLES=4; register expectations go through a
// scoreboard queue filled when stimulus is driven and drained when the bus is sampled.
module tb_key_device;

  localparam logic [31:0] A_KDATA = 32'hFFFF0100;
  localparam logic [31:0] A_KCTRL = 32'hFFFF0104;
  localparam logic [31:0] A_OTHER = 32'hFFFF0108;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] ADDRIN;
  logic [31:0] DIN;
  logic        WE;
  logic        RE;
  logic [31:0] DOUT;
  logic        SEL;
  logic [3:0]  KEY;
  logic        INTR;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  key_device #(
    .DBITS    (32),
    .ADDRKDATA(A_KDATA),
    .ADDRKCTRL(A_KCTRL),
    .DEBCYCLES(4)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .ADDRIN(ADDRIN),
    .DIN   (DIN),
    .WE    (WE),
    .RE    (RE),
    .DOUT  (DOUT),
    .SEL   (SEL),
    .KEY   (KEY),
    .INTR  (INTR)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic expect_reg(input string tag, input logic [31:0] a, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.addr = a;
    e.val  = v;
    sb.push_back(e);
  endtask

  // Pops the oldest expectation and compares DOUT at that address (no bus strobes).
  task automatic check_reg();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_empty: DOUT=%h required a queued expectation", DOUT);
    end
    if (sb.size() != 0) begin
      e      = sb.pop_front();
      ADDRIN = e.addr;
      RE     = 1'b0;
      WE     = 1'b0;
      #1;
      assert (DOUT === e.val) else begin
        errors++;
        $error("FAIL %s: DOUT=%h required %h", e.tag, DOUT, e.val);
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b required %b", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input logic [31:0] a);
    ADDRIN = a;
    RE     = 1'b1;
    step(1);
    RE     = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    ADDRIN = a;
    DIN    = d;
    WE     = 1'b1;
    step(1);
    WE     = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    KEY   = 4'hF;
    WE    = 1'b0;
    RE    = 1'b0;
    step(2);
    RESET = 1'b0;
    step(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET  = 1'b1;
    ADDRIN = '0;
    DIN    = '0;
    WE     = 1'b0;
    RE     = 1'b0;
    KEY    = 4'hF;
    step(2);

    // Reset state while RESET is still asserted
    expect_reg("rst_kdata", A_KDATA, 32'h0000000F);
    expect_reg("rst_kctrl", A_KCTRL, 32'h00000000);
    check_reg();
    check_reg();
    check_bit("rst_intr", INTR, 1'b0);
    ADDRIN = A_KCTRL;
    #1;
    check_bit("rst_sel", SEL, 1'b1);
    RESET = 1'b0;
    step(4);

    // Idle keys read back as all ones, no status
    expect_reg("idle_kdata", A_KDATA, 32'h0000000F);
    expect_reg("idle_kctrl", A_KCTRL, 32'h00000000);
    check_reg();
    bus_read(A_KDATA);
    check_reg();
    check_bit("idle_intr", INTR, 1'b0);
    expect_reg("off_dout", A_OTHER, 32'h0);
    check_reg();
    check_bit("off_sel", SEL, 1'b0);

    // Glitch shorter than DEBCYCLES is rejected
    KEY = 4'hE;
    step(3);
    KEY = 4'hF;
    expect_reg("glitch_kdata", A_KDATA, 32'h0000000F);
    expect_reg("glitch_kctrl", A_KCTRL, 32'h00000000);
    step(10);
    check_reg();
    check_reg();

    // Steady change lands exactly on edge 6
    KEY = 4'hE;
    expect_reg("deb_edge5_kdata", A_KDATA, 32'h0000000F);
    expect_reg("deb_edge6_kdata", A_KDATA, 32'h0000000E);
    expect_reg("deb_edge6_kctrl", A_KCTRL, 32'h00000001);
    step(6);
    check_reg();
    step(1);
    check_reg();
    check_reg();
    check_bit("deb_intr_noie", INTR, 1'b0);
    bus_read(A_KDATA);
    expect_reg("read_clr_kctrl", A_KCTRL, 32'h00000000);
    check_reg();

    // Writes to KDATA have no effect
    bus_write(A_KDATA, 32'h0);
    expect_reg("kdata_wr_ignored", A_KDATA, 32'h0000000E);
    check_reg();

    // Two changes without a read -> Overrun; KCTRL write of 0 clears both
    do_reset();
    KEY = 4'hE;
    step(10);
    KEY = 4'hC;
    step(10);
    expect_reg("ovr_kdata", A_KDATA, 32'h0000000C);
    expect_reg("ovr_kctrl", A_KCTRL, 32'h00000005);
    check_reg();
    check_reg();
    bus_write(A_KCTRL, 32'h0);
    expect_reg("ovr_clr_kctrl", A_KCTRL, 32'h00000000);
    check_reg();

    // Change coinciding with a Ready-clearing KCTRL write: set wins
    KEY = 4'h8;
    expect_reg("setwins_kctrl", A_KCTRL, 32'h00000001);
    step(6);
    bus_write(A_KCTRL, 32'h0);
    check_reg();
    bus_read(A_KDATA);

    // Interrupt enable, then change raises INTR on the Ready edge
    bus_write(A_KCTRL, 32'h10);
    expect_reg("ie_kctrl", A_KCTRL, 32'h00000010);
    check_reg();
    check_bit("ie_intr_idle", INTR, 1'b0);
    KEY = 4'h0;
    expect_reg("intr_kctrl", A_KCTRL, 32'h00000011);
    step(6);
    check_bit("intr_edge5", INTR, 1'b0);
    step(1);
    check_bit("intr_edge6", INTR, 1'b1);
    check_reg();

    // KDATA read on the same edge as a second change: Ready and INTR hold
    KEY = 4'h1;
    expect_reg("rdchg_kctrl", A_KCTRL, 32'h00000011);
    expect_reg("rdchg_kdata", A_KDATA, 32'h00000001);
    step(6);
    ADDRIN = A_KDATA;
    RE     = 1'b1;
    step(1);
    RE     = 1'b0;
    check_bit("rdchg_intr", INTR, 1'b1);
    check_reg();
    check_reg();
    bus_read(A_KDATA);
    check_bit("rd_intr_clr", INTR, 1'b0);
    expect_reg("rd_kctrl_ie", A_KCTRL, 32'h00000010);
    check_reg();

    // Reset mid-debounce aborts; held key re-debounced from zero
    KEY = 4'h7;
    step(3);
    RESET = 1'b1;
    expect_reg("midrst_kdata", A_KDATA, 32'h0000000F);
    expect_reg("midrst_kctrl", A_KCTRL, 32'h00000000);
    step(1);
    check_reg();
    check_reg();
    check_bit("midrst_intr", INTR, 1'b0);
    RESET = 1'b0;
    expect_reg("postrst_edge5", A_KDATA, 32'h0000000F);
    expect_reg("postrst_edge6", A_KDATA, 32'h00000007);
    step(6);
    check_reg();
    step(1);
    check_reg();

    check_bit("sb_drained", sb.size() == 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
